// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_OFF_W     = $clog2(BYTES_PER_WORD);

    localparam logic ERR_NONE   = 1'b0;
    localparam logic ERR_ACCESS = 1'b1;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response channels between the CPU data port and the memory responder.
interface dmem_responder_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_be;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_array.sv
// Single-port word storage with byte-enabled write and registered read.
// Latency: read data valid one edge after en.
// Backpressure: none; the caller only enables it on the commit edge.
module dmem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = 8
) (
    input  logic                clk,
    input  logic                en,
    input  logic                we,
    input  logic [IDX_W-1:0]    idx,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] be,
    output logic [DATA_W-1:0]   rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < DATA_W/8; i++) begin
                    if (be[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
            rdata <= mem[idx];
        end
    end
endmodule

// File: rtl/dmem_responder.sv
// One-at-a-time load/store responder in front of a backing word array.
// Latency: rsp_valid rises WAIT_CYCLES+1 edges after the accepting edge.
// Backpressure: req_ready low until the response is taken; response held while rsp_ready low.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int                DATA_W      = 32,
    parameter int                ADDR_W      = 32,
    parameter int                DEPTH       = 256,
    parameter int                WAIT_CYCLES = 2,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
    input logic              clk,
    input logic              rst,
    dmem_responder_if.slave  bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int BE_W  = DATA_W / 8;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic                lat_we;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic [BE_W-1:0]     lat_be;
    logic                rsp_err_q, rsp_zero_q;
    logic                accept, rsp_take, commit;
    logic                req_ready_c, rsp_valid_c;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr, off;
    logic [DATA_W-1:0]   sel_wdata, arr_rdata;
    logic [BE_W-1:0]     sel_be;
    logic                addr_err;

    assign accept   = bus.req_valid && (state == ST_IDLE);
    assign rsp_take = bus.rsp_ready && (state == ST_RESP);

    // With no wait states the commit shares the accept edge, so decode the live request.
    always_comb begin
        sel_we    = lat_we;
        sel_addr  = lat_addr;
        sel_wdata = lat_wdata;
        sel_be    = lat_be;
        if (state == ST_IDLE) begin
            sel_we    = bus.req_we;
            sel_addr  = bus.req_addr;
            sel_wdata = bus.req_wdata;
            sel_be    = bus.req_be;
        end
    end

    assign off      = sel_addr - BASE_ADDR;
    assign addr_err = (sel_addr[BYTE_OFF_W-1:0] != '0) || (sel_addr < BASE_ADDR) ||
                      ((off >> BYTE_OFF_W) >= ADDR_W'(DEPTH));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
            ST_WAIT: if (cnt == '0) state_nxt = ST_RESP;
            ST_RESP: if (rsp_take) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready_c = 1'b0;
        rsp_valid_c = 1'b0;
        commit      = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready_c = 1'b1;
                commit      = accept && (WAIT_CYCLES == 0);
            end
            ST_WAIT: commit      = (cnt == '0);
            ST_RESP: rsp_valid_c = 1'b1;
            default: ;
        endcase
    end

    // Counter holds the wait cycles still owed before the commit edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_be     <= '0;
            rsp_err_q  <= ERR_NONE;
            rsp_zero_q <= 1'b1;
        end else begin
            if (accept) begin
                lat_we    <= bus.req_we;
                lat_addr  <= bus.req_addr;
                lat_wdata <= bus.req_wdata;
                lat_be    <= bus.req_be;
                cnt       <= CNT_W'(WAIT_CYCLES);
            end else if ((state == ST_WAIT) && (cnt != '0)) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (commit) begin
                rsp_err_q  <= addr_err ? ERR_ACCESS : ERR_NONE;
                rsp_zero_q <= addr_err || sel_we;
            end
        end
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clk),
        .en    (commit),
        .we    (sel_we && !addr_err),
        .idx   (off[IDX_W+BYTE_OFF_W-1:BYTE_OFF_W]),
        .wdata (sel_wdata),
        .be    (sel_be),
        .rdata (arr_rdata)
    );

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_c;
    assign bus.rsp_err   = (state == ST_RESP) ? rsp_err_q : ERR_NONE;
    assign bus.rsp_rdata = ((state == ST_RESP) && !rsp_zero_q) ? arr_rdata : '0;
endmodule

// File: tb/tb_dmem_responder.sv
// Vector table plus hand sequences for stall and mid-transaction reset, checked via a response scoreboard.
module tb_dmem_responder;
    logic clk = 1'b0;
    logic rst = 1'b0;

    dmem_responder_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    dmem_responder #(
        .DATA_W(32), .ADDR_W(32), .DEPTH(256), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];
    rsp_t sb [$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic drive_req(input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be);
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_be    = be;
        bus.req_valid = 1'b1;
    endtask

    // Waits for rsp_valid; returns the number of edges since the accept edge.
    task automatic wait_rsp(output int n);
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic pop_compare(input string name);
        rsp_t e;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s_sb got=empty exp=entry", name);
        end else begin
            e = sb.pop_front();
            check({name, "_rdata"}, bus.rsp_rdata, e.rdata);
            check({name, "_err"}, {31'b0, bus.rsp_err}, {31'b0, e.err});
        end
    endtask

    task automatic txn(input vec_t v, input string name);
        int n;
        check({name, "_req_ready"}, {31'b0, bus.req_ready}, 32'd1);
        drive_req(v.we, v.addr, v.wdata, v.be);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        sb.push_back(rsp_t'{rdata: v.exp_rdata, err: v.exp_err});
        wait_rsp(n);
        check({name, "_latency"}, n, 32'd3);
        pop_compare(name);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        check({name, "_done_valid"}, {31'b0, bus.rsp_valid}, 32'd0);
        check({name, "_done_ready"}, {31'b0, bus.req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        vec_t v;

        vecs[0]  = '{1'b1, 32'h000, 32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
        vecs[1]  = '{1'b1, 32'h010, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        vecs[2]  = '{1'b0, 32'h010, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
        vecs[3]  = '{1'b1, 32'h010, 32'h0000AA00, 4'h2, 32'h0,        1'b0};
        vecs[4]  = '{1'b0, 32'h010, 32'h0,        4'hF, 32'hDEADAAEF, 1'b0};
        vecs[5]  = '{1'b1, 32'h010, 32'hFFFFFFFF, 4'h0, 32'h0,        1'b0};
        vecs[6]  = '{1'b0, 32'h010, 32'h0,        4'hF, 32'hDEADAAEF, 1'b0};
        vecs[7]  = '{1'b0, 32'h012, 32'h0,        4'hF, 32'h0,        1'b1};
        vecs[8]  = '{1'b0, 32'h400, 32'h0,        4'hF, 32'h0,        1'b1};
        vecs[9]  = '{1'b1, 32'h400, 32'h11111111, 4'hF, 32'h0,        1'b1};
        vecs[10] = '{1'b0, 32'h000, 32'h0,        4'hF, 32'hCAFEF00D, 1'b0};
        vecs[11] = '{1'b1, 32'h3FC, 32'h01234567, 4'hF, 32'h0,        1'b0};
        vecs[12] = '{1'b1, 32'h3FC, 32'hA5A5A5A5, 4'h9, 32'h0,        1'b0};
        vecs[13] = '{1'b0, 32'h3FC, 32'h0,        4'h0, 32'hA52345A5, 1'b0};
        vecs[14] = '{1'b1, 32'h011, 32'h00000000, 4'hF, 32'h0,        1'b1};
        vecs[15] = '{1'b0, 32'h010, 32'h0,        4'hF, 32'hDEADAAEF, 1'b0};
        vecs[16] = '{1'b1, 32'h020, 32'h00000000, 4'hF, 32'h0,        1'b0};
        vecs[17] = '{1'b0, 32'h020, 32'h0,        4'hF, 32'h0,        1'b0};

        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_be    = '0;
        bus.rsp_ready = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
            check("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
            check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
            check("rst_rsp_err", {31'b0, bus.rsp_err}, 32'd0);
        end
        rst = 1'b1;

        bus.rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        check("idle_req_ready", {31'b0, bus.req_ready}, 32'd1);
        check("idle_rsp_err", {31'b0, bus.rsp_err}, 32'd0);
        bus.rsp_ready = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            txn(vecs[i], $sformatf("vec%0d", i));
        end

        // Response held under backpressure; a request pulse during RESP must be dropped.
        drive_req(1'b0, 32'h010, 32'h0, 4'hF);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        sb.push_back(rsp_t'{rdata: 32'hDEADAAEF, err: 1'b0});
        wait_rsp(n);
        check("stall_latency", n, 32'd3);
        pop_compare("stall");
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", {31'b0, bus.rsp_valid}, 32'd1);
            check("stall_rdata", bus.rsp_rdata, 32'hDEADAAEF);
            check("stall_err", {31'b0, bus.rsp_err}, 32'd0);
            check("stall_req_ready", {31'b0, bus.req_ready}, 32'd0);
            if (i == 1) drive_req(1'b1, 32'h010, 32'h0, 4'hF);
            @(posedge clk); #1;
            bus.req_valid = 1'b0;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        check("stall_release_valid", {31'b0, bus.rsp_valid}, 32'd0);
        check("stall_release_ready", {31'b0, bus.req_ready}, 32'd1);
        v = '{1'b0, 32'h010, 32'h0, 4'hF, 32'hDEADAAEF, 1'b0};
        txn(v, "after_stall");

        // Reset while the store is still waiting: it must never reach the array.
        drive_req(1'b1, 32'h020, 32'h12345678, 4'hF);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        check("wait_req_ready", {31'b0, bus.req_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check("midrst_req_ready", {31'b0, bus.req_ready}, 32'd1);
        check("midrst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("postrst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        end
        v = '{1'b0, 32'h020, 32'h0, 4'hF, 32'h0, 1'b0};
        txn(v, "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
